// File: rtl/gpio_disp_pkg.sv
// Shared types and segment constants for the GPIO BCD display.
// Segments are active-low, bit0=a through bit6=g.
package gpio_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment map.
// Non-decimal codes map to blank.
module seg7_decode
  import gpio_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/gpio_bcd_display.sv
// Serial double-dabble of a 32-bit GPIO word onto eight
// seven-segment digits, with leading-zero blanking and overflow dashes.
module gpio_bcd_display
  import gpio_disp_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy,
  output logic        overflow
);

  localparam logic [6:0] SEG_UP =
    BLANK_LZ ? SEG_BLANK : SEG_0;

  state_e state_q, state_d;
  logic [31:0] last_q, last_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] bcd_q, bcd_d;
  logic [4:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        ovfo_q, ovfo_d;
  logic [7:0][6:0] hex_q, hex_d;

  logic [31:0] bcd_adj;
  logic [7:0][6:0] seg_raw;
  logic [7:0][6:0] seg_fin;
  logic lead;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg7_decode u_dec (
      .digit_i (bcd_q[4*g +: 4]),
      .seg_o   (seg_raw[g])
    );
  end

  // Blank from the top down until the first nonzero digit.
  always_comb begin
    seg_fin = seg_raw;
    lead = BLANK_LZ;
    for (int i = 7; i >= 1; i--) begin
      if (lead && bcd_q[4*i +: 4] == 4'd0)
        seg_fin[i] = SEG_BLANK;
      else
        lead = 1'b0;
    end
    if (ovf_q) begin
      for (int i = 0; i < 8; i++)
        seg_fin[i] = SEG_DASH;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    ovfo_d  = ovfo_q;
    hex_d   = hex_q;
    unique case (state_q)
      IDLE: begin
        if (value != last_q) begin
          last_d  = value;
          shift_d = value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        ovf_d = ovf_q | bcd_adj[31];
        {bcd_d, shift_d} = {bcd_adj[30:0], shift_q, 1'b0};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31)
          state_d = COMMIT;
      end
      COMMIT: begin
        hex_d   = seg_fin;
        ovfo_d  = ovf_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovfo_q  <= 1'b0;
      hex_q   <= {{7{SEG_UP}}, SEG_0};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ovfo_q  <= ovfo_d;
      hex_q   <= hex_d;
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign hex6     = hex_q[6];
  assign hex7     = hex_q[7];
  assign busy     = busy_q;
  assign overflow = ovfo_q;

endmodule
